// File: rtl/div_restoring.sv
`default_nettype none
// ============================================================================
// Module   : div_restoring
// Purpose  : Sequential unsigned restoring divider, one quotient bit per clock,
//            with start/busy/done handshake and divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module div_restoring #(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         div_by_zero_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N:0]     a_q, a_d;
  logic [N-1:0]   q_q, q_d;
  logic [N:0]     m_q, m_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dbz_q, dbz_d;

  // A[N] is zero between iterations, so carrying it one bit wider makes the
  // top bit of the difference the borrow, identical to the sign of A-M.
  logic [N+1:0]   a_sh;
  logic [N+1:0]   diff;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    a_sh    = {a_q, q_q[N-1]};
    diff    = a_sh - {1'b0, m_q};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (divisor_i != '0) begin
            a_d     = '0;
            q_d     = dividend_i;
            m_d     = {1'b0, divisor_i};
            cnt_d   = CW'(N);
            dbz_d   = 1'b0;
            state_d = S_ITER;
          end else begin
            a_d     = {1'b0, dividend_i};
            q_d     = '1;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_ITER: begin
        if (diff[N+1]) begin
          a_d = a_sh[N:0];
          q_d = {q_q[N-2:0], 1'b0};
        end else begin
          a_d = diff[N:0];
          q_d = {q_q[N-2:0], 1'b1};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o        = (state_q == S_ITER);
  assign done_o        = (state_q == S_DONE);
  assign div_by_zero_o = dbz_q;
  assign quotient_o    = q_q;
  assign remainder_o   = a_q[N-1:0];

endmodule
`default_nettype wire

// File: tb/tb_div_restoring.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_restoring
// Purpose  : Self-checking bench for div_restoring (N=3 and N=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_restoring;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       st3 = 1'b0;
  logic [2:0] dd3 = '0, dv3 = '0;
  logic       busy3, done3, dbz3;
  logic [2:0] q3, r3;

  logic       st4 = 1'b0;
  logic [3:0] dd4 = '0, dv4 = '0;
  logic       busy4, done4, dbz4;
  logic [3:0] q4, r4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_restoring #(.N(3)) u_dut3 (
    .clk_i(clk), .reset_i(rst), .start_i(st3), .dividend_i(dd3), .divisor_i(dv3),
    .busy_o(busy3), .done_o(done3), .div_by_zero_o(dbz3),
    .quotient_o(q3), .remainder_o(r3)
  );

  div_restoring #(.N(4)) u_dut4 (
    .clk_i(clk), .reset_i(rst), .start_i(st4), .dividend_i(dd4), .divisor_i(dv4),
    .busy_o(busy4), .done_o(done4), .div_by_zero_o(dbz4),
    .quotient_o(q4), .remainder_o(r4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input bit s, input int dd, input int dv);
    if (w == 3) begin
      st3 = s; dd3 = dd[2:0]; dv3 = dv[2:0];
    end else begin
      st4 = s; dd4 = dd[3:0]; dv4 = dv[3:0];
    end
  endtask

  function automatic logic [31:0] get_q(input int w);
    return (w == 3) ? {29'b0, q3} : {28'b0, q4};
  endfunction
  function automatic logic [31:0] get_r(input int w);
    return (w == 3) ? {29'b0, r3} : {28'b0, r4};
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 3) ? busy3 : busy4;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 3) ? done3 : done4;
  endfunction
  function automatic logic get_dbz(input int w);
    return (w == 3) ? dbz3 : dbz4;
  endfunction

  // Reference: plain integer division; divide-by-zero yields all-ones / dividend.
  task automatic run_div(input int w, input int dd, input int dv);
    int mask  = (1 << w) - 1;
    int eq    = (dv == 0) ? mask : dd / dv;
    int er    = (dv == 0) ? dd : dd % dv;
    int iters = (dv == 0) ? 0 : w;
    logic edbz = (dv == 0);
    drive(w, 1'b1, dd, dv);
    tick;
    for (int i = 0; i < iters; i++) begin
      drive(w, 1'b0, $urandom, $urandom);
      checks++;
      if (get_busy(w) !== 1'b1 || get_done(w) !== 1'b0) begin
        errors++;
        $display("FAIL busy N=%0d %0d/%0d iter %0d: busy=%b done=%b, want busy=1 done=0",
                 w, dd, dv, i, get_busy(w), get_done(w));
      end
      tick;
    end
    drive(w, 1'b0, $urandom, $urandom);
    checks++;
    if (get_done(w) !== 1'b1 || get_busy(w) !== 1'b0) begin
      errors++;
      $display("FAIL done_latency N=%0d %0d/%0d: done=%b busy=%b, want done=1 busy=0",
               w, dd, dv, get_done(w), get_busy(w));
    end
    checks++;
    if (get_q(w) !== eq || get_r(w) !== er || get_dbz(w) !== edbz) begin
      errors++;
      $display("FAIL result N=%0d %0d/%0d: q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
               w, dd, dv, get_q(w), get_r(w), get_dbz(w), eq, er, edbz);
    end
    tick;
    checks++;
    if (get_done(w) !== 1'b0 || get_q(w) !== eq || get_r(w) !== er) begin
      errors++;
      $display("FAIL after_done N=%0d %0d/%0d: done=%b q=%0d r=%0d, want done=0 q=%0d r=%0d",
               w, dd, dv, get_done(w), get_q(w), get_r(w), eq, er);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(3, 1'b1, 7, 2);
    drive(4, 1'b1, 9, 2);
    tick;
    tick;
    rst = 1'b0;
    drive(3, 1'b0, 0, 0);
    drive(4, 1'b0, 0, 0);
    checks++;
    if ({busy3, done3, dbz3, q3, r3} !== 9'b0) begin
      errors++;
      $display("FAIL reset_n3: busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               busy3, done3, dbz3, q3, r3);
    end
    checks++;
    if ({busy4, done4, dbz4, q4, r4} !== 11'b0) begin
      errors++;
      $display("FAIL reset_n4: busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               busy4, done4, dbz4, q4, r4);
    end
    tick;
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_start: busy=%b done=%b, want 0 0", busy3, done3);
    end
  endtask

  task automatic test_patterns;
    run_div(3, 7, 2);
    run_div(3, 6, 3);
    run_div(3, 0, 7);
    run_div(3, 2, 5);
    for (int i = 0; i < 4; i++) begin
      drive(3, 1'b0, $urandom, $urandom);
      tick;
    end
    checks++;
    if (q3 !== 3'd0 || r3 !== 3'd2 || done3 !== 1'b0) begin
      errors++;
      $display("FAIL hold: q=%0d r=%0d done=%b, want q=0 r=2 done=0", q3, r3, done3);
    end
  endtask

  task automatic test_div_zero;
    run_div(3, 5, 0);
    run_div(3, 4, 2);
  endtask

  task automatic test_ignore_start;
    int pulses = 0;
    int done_at = -1;
    drive(3, 1'b1, 7, 2);
    tick;
    for (int c = 1; c <= 6; c++) begin
      drive(3, (c == 2), 1, 1);
      if (done3 === 1'b1) begin
        pulses++;
        done_at = c;
      end
      tick;
    end
    drive(3, 1'b0, 0, 0);
    checks++;
    if (pulses != 1 || done_at != 4) begin
      errors++;
      $display("FAIL ignore_start_done: pulses=%0d at=%0d, want 1 at 4", pulses, done_at);
    end
    checks++;
    if (q3 !== 3'd3 || r3 !== 3'd1) begin
      errors++;
      $display("FAIL ignore_start_result: q=%0d r=%0d, want q=3 r=1", q3, r3);
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    drive(3, 1'b1, 7, 3);
    tick;
    drive(3, 1'b0, 7, 3);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({busy3, done3, dbz3, q3, r3} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               busy3, done3, dbz3, q3, r3);
    end
    for (int c = 0; c < 5; c++) begin
      if (done3 === 1'b1) pulses++;
      tick;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: pulses=%0d, want 0", pulses);
    end
    run_div(3, 7, 3);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      run_div(3, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end
  endtask

  task automatic test_back_to_back;
    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 0; dv < 16; dv++) begin
        run_div(4, dd, dv);
      end
    end
    run_div(4, 15, 1);
  endtask

  initial begin
    test_reset;
    test_patterns;
    test_div_zero;
    test_ignore_start;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
